// File: rtl/soft_proc_pkg.sv
// soft_proc_pkg: opcode constants and sequencer state encoding shared by the soft processor run-control logic
package soft_proc_pkg;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_JZ  = 4'hD;
  localparam logic [3:0] OP_JC  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_ISSUE,
    S_SETTLE,
    S_BRK,
    S_HALT
  } seq_state_t;
endpackage

// File: rtl/exec_sequencer_rate_divider.sv
// rate_divider: free-run pacing counter, tc pulses on the last of RATE_DIV enabled cycles
//   clk, rst : clock, sync active-high reset
//   en       : count while high
//   clr      : force count back to zero
//   tc       : one-cycle terminal-count pulse
module rate_divider #(
  parameter int RATE_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);
  localparam int W = $clog2(RATE_DIV);
  logic [W-1:0] cnt_q;
  assign tc = en && cnt_q == W'(RATE_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) cnt_q <= '0;
    else if (en) cnt_q <= tc ? '0 : cnt_q + 1'b1;
  end
endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: run-control sequencer turning button pulses into core step strobes
//   SYSCLK, RESET                 : clock, sync active-high reset
//   STEP_REQ, RUN_REQ, CLEAR_REQ  : one-cycle request pulses
//   PC, OPCODE                    : current core PC and opcode at PC
//   BP_EN, BP_ADDR                : PC breakpoint
//   STEP_OUT                      : one-cycle step strobe to the core
//   RUNNING, HALTED, BP_HIT       : status decoded from state
//   INSTR_CNT                     : saturating count of issued steps
module exec_sequencer
  import soft_proc_pkg::*;
#(
  parameter int RATE_DIV = 25_000_000,
  parameter int CNT_W    = 8
) (
  input  logic             SYSCLK,
  input  logic             RESET,
  input  logic             STEP_REQ,
  input  logic             RUN_REQ,
  input  logic             CLEAR_REQ,
  input  logic [3:0]       PC,
  input  logic [3:0]       OPCODE,
  input  logic             BP_EN,
  input  logic [3:0]       BP_ADDR,
  output logic             STEP_OUT,
  output logic             RUNNING,
  output logic             HALTED,
  output logic             BP_HIT,
  output logic [CNT_W-1:0] INSTR_CNT
);
  seq_state_t state_q, state_d, ret_q, ret_d;
  logic skip_q, skip_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic tc;
  logic is_hlt;
  assign is_hlt = OPCODE == OP_HLT;
  // Divider only runs in RUN and is held at zero everywhere else, so every RUN entry starts a fresh period.
  rate_divider #(.RATE_DIV(RATE_DIV)) u_div (
    .clk (SYSCLK),
    .rst (RESET),
    .en  (state_q == S_RUN),
    .clr (CLEAR_REQ || state_q != S_RUN),
    .tc  (tc)
  );
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    skip_d  = skip_q;
    cnt_d   = cnt_q;
    if (CLEAR_REQ) begin
      state_d = S_IDLE;
      skip_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (STEP_REQ) begin
            state_d = is_hlt ? S_HALT : S_ISSUE;
            ret_d   = S_IDLE;
          end else if (RUN_REQ) state_d = S_RUN;
        end
        S_RUN: begin
          if (RUN_REQ) state_d = S_IDLE;
          else if (tc) begin
            if (is_hlt) state_d = S_HALT;
            else if (BP_EN && PC == BP_ADDR && !skip_q) state_d = S_BRK;
            else begin
              state_d = S_ISSUE;
              ret_d   = S_RUN;
              skip_d  = 1'b0;
            end
          end
        end
        S_ISSUE: begin
          state_d = S_SETTLE;
          cnt_d   = &cnt_q ? cnt_q : cnt_q + 1'b1;
        end
        S_SETTLE: state_d = ret_q;
        S_BRK: begin
          if (STEP_REQ) begin
            state_d = is_hlt ? S_HALT : S_ISSUE;
            ret_d   = S_IDLE;
          end else if (RUN_REQ) begin
            // Resume lets the breakpoint instruction itself execute once.
            state_d = S_RUN;
            skip_d  = 1'b1;
          end
        end
        S_HALT: state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      skip_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      skip_q  <= skip_d;
      cnt_q   <= cnt_d;
    end
  end
  assign STEP_OUT  = state_q == S_ISSUE;
  assign RUNNING   = state_q == S_RUN || ((state_q == S_ISSUE || state_q == S_SETTLE) && ret_q == S_RUN);
  assign HALTED    = state_q == S_HALT;
  assign BP_HIT    = state_q == S_BRK;
  assign INSTR_CNT = cnt_q;
endmodule
